// File: rtl/rf_multiport_sb.sv
// Register file with NR combinational read ports, one write port, a pending-write
// scoreboard, a one-entry-per-cycle clear sweep and a registered debug port.
// Optional macro RF_BYPASS_EN: write-first forwarding on the read ports.
module rf_multiport_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rpend,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   cnt_r, cnt_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            clr_all_s;
  logic            wr_s, iss_s;
  logic [DW-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DW-1:0]   dbg_r;

  assign wr_s     = we && (waddr != ZERO_IDX) && !busy_r;
  assign iss_s    = iss_valid && (iss_addr != ZERO_IDX) && !busy_r;
  assign clr_busy = busy_r;
  assign dbg_data = dbg_r;

  // Clear sequencer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    clr_all_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_nxt_s = SWEEP;
          cnt_nxt_s   = {{(AW-1){1'b0}}, 1'b1};
          clr_all_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SWEEP: begin
        cnt_nxt_s = cnt_r + {{(AW-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SWEEP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = ZERO_IDX;
      end
    endcase
    busy_nxt_s = (state_nxt_s == SWEEP);
  end

  // Clear sequencer state, counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= ZERO_IDX;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Storage: the sweep owns the write path while it runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (state_r == SWEEP) begin
      mem_r[cnt_r] <= {DW{1'b0}};
    end else if (wr_s) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[0] <= {DW{1'b0}};
    end
  end

  // Scoreboard: issue is applied after the write so a same-edge issue wins.
  always_ff @(posedge clk) begin
    if (rst || clr_all_s) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      if (wr_s) begin
        pend_r[waddr] <= 1'b0;
      end
      if (iss_s) begin
        pend_r[iss_addr] <= 1'b1;
      end
    end
  end

  // Debug tap samples the pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_r <= {DW{1'b0}};
    end else if (dbg_addr == ZERO_IDX) begin
      dbg_r <= {DW{1'b0}};
    end else begin
      dbg_r <= mem_r[dbg_addr];
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata = {(NR*DW){1'b0}};
    rpend = {NR{1'b0}};
    for (int i = 0; i < NR; i++) begin
      if (raddr[i*AW +: AW] == ZERO_IDX) begin
        rdata[i*DW +: DW] = {DW{1'b0}};
        rpend[i]          = 1'b0;
`ifdef RF_BYPASS_EN
      end else if (wr_s && (raddr[i*AW +: AW] == waddr)) begin
        rdata[i*DW +: DW] = wdata;
        rpend[i]          = iss_s && (iss_addr == waddr);
`endif
      end else begin
        rdata[i*DW +: DW] = mem_r[raddr[i*AW +: AW]];
        rpend[i]          = pend_r[raddr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench for rf_multiport_sb with a cycle-level reference model of the
// register file contents, pending bits, clear sweep and debug tap.
module tb_rf_multiport_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rpend;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             iss_valid;
  logic [AW-1:0]    iss_addr;
  logic             clr_req;
  logic             clr_busy;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;

  int checks = 0;
  int errors = 0;

  rf_multiport_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state after each edge.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_busy;
  int            m_left;
  logic [DW-1:0] m_dbg;
  bit            m_ok = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
      m_busy <= 1'b0;
      m_left <= 0;
      m_dbg  <= '0;
      m_ok   <= 1'b1;
    end else begin
      m_dbg <= (dbg_addr == 0) ? '0 : m_mem[dbg_addr];
      if (m_busy) begin
        // Entry swept this edge is DEPTH - m_left; the sweep runs entries 1..DEPTH-1.
        m_mem[DEPTH - m_left] <= '0;
        m_left <= m_left - 1;
        if (m_left == 1) m_busy <= 1'b0;
      end else begin
        if (we && waddr != 0) begin
          m_mem[waddr]  <= wdata;
          m_pend[waddr] <= 1'b0;
        end
        if (iss_valid && iss_addr != 0) m_pend[iss_addr] <= 1'b1;
        if (clr_req) begin
          for (int i = 0; i < DEPTH; i++) m_pend[i] <= 1'b0;
          m_busy <= 1'b1;
          m_left <= DEPTH - 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_ok && !rst) begin
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          ep;
        a  = raddr[p*AW +: AW];
        ed = (a == 0) ? '0 : m_mem[a];
        ep = (a == 0) ? 1'b0 : m_pend[a];
`ifdef RF_BYPASS_EN
        if (we && !m_busy && waddr != 0 && a == waddr) begin
          ed = wdata;
          ep = iss_valid && iss_addr == waddr;
        end
`endif
        chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], ed);
        chk($sformatf("rpend%0d", p), {31'd0, rpend[p]}, {31'd0, ep});
      end
      chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_busy});
      chk("dbg_data", dbg_data, m_dbg);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_addr = '0; clr_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; raddr = '0; dbg_addr = '0;
    idle_inputs();
    step(); step();
    rst = 1'b0;

    // T1 reset clears a loaded entry
    wr(5'd5, 32'hDEAD);
    raddr = {5'd0, 5'd5}; dbg_addr = 5'd5;
    #1 chk("t1_loaded", rdata[31:0], 32'hDEAD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t1_rdata", rdata[31:0], 32'h0);
    chk("t1_rpend", {30'd0, rpend}, 32'h0);
    chk("t1_busy", {31'd0, clr_busy}, 32'h0);
    chk("t1_dbg", dbg_data, 32'h0);

    // T2 writes and issues to x0 are dropped
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; iss_valid = 1'b1; iss_addr = 5'd0;
    step();
    idle_inputs();
    raddr = '0;
    #1;
    chk("t2_rd0", rdata[31:0], 32'h0);
    chk("t2_rd1", rdata[63:32], 32'h0);
    chk("t2_pend", {30'd0, rpend}, 32'h0);

    // T3 scoreboard
    iss_valid = 1'b1; iss_addr = 5'd7;
    step();
    idle_inputs();
    raddr = {5'd7, 5'd7};
    #1 chk("t3_pend_set", {30'd0, rpend}, 32'h3);
    wr(5'd7, 32'h55);
    #1;
    chk("t3_pend_clr", {31'd0, rpend[0]}, 32'h0);
    chk("t3_data", rdata[31:0], 32'h55);
    we = 1'b1; waddr = 5'd7; wdata = 32'h66; iss_valid = 1'b1; iss_addr = 5'd7;
    step();
    idle_inputs();
    #1;
    chk("t3_same_pend", {31'd0, rpend[1]}, 32'h1);
    chk("t3_same_data", rdata[63:32], 32'h66);

    // T4 read of an entry being written
    raddr = {5'd0, 5'd3};
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5;
    #1;
`ifdef RF_BYPASS_EN
    chk("t4_same_cycle", rdata[31:0], 32'hA5A5);
`else
    chk("t4_same_cycle", rdata[31:0], 32'h0);
`endif
    dbg_addr = 5'd3;
    step();
    we = 1'b0;
    #1;
    chk("t4_next", rdata[31:0], 32'hA5A5);
    chk("t4_dbg_old", dbg_data, 32'h0);
    step();
    chk("t4_dbg_new", dbg_data, 32'hA5A5);

    // T5 full sweep
    for (int i = 1; i < DEPTH; i++) wr(i[4:0], i);
    raddr = {5'd9, 5'd31}; dbg_addr = 5'd9;
    #1 chk("t5_x31", rdata[31:0], 32'd31);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 20) begin
        we = 1'b1; waddr = 5'd9; wdata = 32'h77; iss_valid = 1'b1; iss_addr = 5'd9;
      end else if (n == 25) begin
        clr_req = 1'b1;
      end else begin
        idle_inputs();
      end
      step();
      n++;
    end
    idle_inputs();
    chk("t5_busy_cycles", n, 32'd31);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      raddr = {i[4:0], i[4:0]};
      #1;
      chk("t5_cleared", rdata[31:0], 32'h0);
      chk("t5_pend_clr", {30'd0, rpend}, 32'h0);
    end
    step();

    // T6 reset during a sweep
    wr(5'd4, 32'h44);
    wr(5'd20, 32'h20);
    wr(5'd30, 32'h30);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("t6_busy_mid", {31'd0, clr_busy}, 32'h1);
    raddr = {5'd30, 5'd20};
    #1 chk("t6_x20_mid", rdata[31:0], 32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_busy", {31'd0, clr_busy}, 32'h0);
    chk("t6_x20", rdata[31:0], 32'h0);
    chk("t6_x30", rdata[63:32], 32'h0);
    wr(5'd12, 32'hC0DE);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("t6_restart", {31'd0, clr_busy}, 32'h1);
    n = 0;
    while (clr_busy && n < 100) begin
      step();
      n++;
    end
    chk("t6_busy_cycles", n, 32'd31);
    raddr = {5'd0, 5'd12};
    #1 chk("t6_x12", rdata[31:0], 32'h0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
